// File: rtl/hu_sysarray_arb_pkg.sv
// Shared AXI widths, response codes and arbiter state type for the systolic-array
// read/write arbiters.
package hu_sysarray_arb_pkg;

  localparam int unsigned AXI_ADDR_W = 32;
  localparam int unsigned AXI_DATA_W = 64;
  localparam int unsigned AXI_ID_W   = 10;
  localparam int unsigned AXI_LEN_W  = 8;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } axi_resp_t;

  typedef enum logic {
    IDLE,
    ISSUE
  } arb_state_t;

endpackage

// File: rtl/hu_sysarray_rr_arbiter.sv
// Combinational rotate-priority encoder: grants the first requester found searching
// upward from ptr+1 with wrap-around.
module hu_sysarray_rr_arbiter #(
  parameter int unsigned N  = 3,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          any
);

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    for (int unsigned k = 1; k <= N; k++) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (!any && req[i] && (i == ((32'(ptr) + k) % N))) begin
          any     = 1'b1;
          gnt[i]  = 1'b1;
          gnt_idx = IW'(i);
        end
      end
    end
  end

endmodule

// File: rtl/hu_sysarray_rd_arb.sv
// Round-robin AXI read-channel arbiter for the systolic-array fetch engines, with
// per-requester outstanding-burst limits and rid-based R steering.
// Optional AR stall counter: define HU_SYSARRAY_ARB_PERF_EN.
module hu_sysarray_rd_arb
  import hu_sysarray_arb_pkg::*;
#(
  parameter int unsigned NREQ      = 3,
  parameter int unsigned MAX_OUTST = 4,
  parameter int unsigned IDX_W     = $clog2(NREQ)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req_ar_valid,
  output logic [NREQ-1:0]            req_ar_ready,
  input  logic [NREQ*AXI_ADDR_W-1:0] req_ar_addr,
  input  logic [NREQ*AXI_LEN_W-1:0]  req_ar_len,
  output logic [NREQ-1:0]            req_r_valid,
  input  logic [NREQ-1:0]            req_r_ready,
  output logic [AXI_DATA_W-1:0]      req_r_data,
  output logic [1:0]                 req_r_resp,
  output logic                       req_r_last,
  output logic                       m_arvalid,
  input  logic                       m_arready,
  output logic [AXI_ID_W-1:0]        m_arid,
  output logic [AXI_ADDR_W-1:0]      m_araddr,
  output logic [AXI_LEN_W-1:0]       m_arlen,
  input  logic                       m_rvalid,
  output logic                       m_rready,
  input  logic [AXI_ID_W-1:0]        m_rid,
  input  logic [AXI_DATA_W-1:0]      m_rdata,
  input  logic [1:0]                 m_rresp,
  input  logic                       m_rlast,
  output logic                       err,
  output logic [31:0]                perf_ar_stall_cnt
);

  localparam int unsigned CNT_W = 4;

  arb_state_t              state_q, state_d;
  logic [IDX_W-1:0]        ptr_q, ar_idx_q;
  logic [AXI_ADDR_W-1:0]   ar_addr_q, sel_addr;
  logic [AXI_LEN_W-1:0]    ar_len_q, sel_len;
  logic [CNT_W-1:0]        cnt_q [NREQ];
  logic [CNT_W-1:0]        cnt_d [NREQ];
  logic                    err_q, err_d;
  logic [NREQ-1:0]         eligible, gnt;
  logic [IDX_W-1:0]        gnt_idx;
  logic                    gnt_any;
  logic [IDX_W-1:0]        r_idx;
  logic                    beat_ok, sel_rready, ar_fire, r_fire;

  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      eligible[i] = req_ar_valid[i] && (cnt_q[i] != CNT_W'(MAX_OUTST));
    end
  end

  hu_sysarray_rr_arbiter #(
    .N  (NREQ),
    .IW (IDX_W)
  ) u_rr (
    .req     (eligible),
    .ptr     (ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (gnt_any)
  );

  always_comb begin
    sel_addr = '0;
    sel_len  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        sel_addr = req_ar_addr[i*AXI_ADDR_W +: AXI_ADDR_W];
        sel_len  = req_ar_len[i*AXI_LEN_W +: AXI_LEN_W];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (gnt_any) state_d = ISSUE;
      ISSUE:   if (m_arready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ar_ready = '0;
    m_arvalid    = 1'b0;
    if (state_q == IDLE) req_ar_ready = gnt;
    else                 m_arvalid    = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q     <= '0;
      ar_idx_q  <= '0;
      ar_addr_q <= '0;
      ar_len_q  <= '0;
    end else if (state_q == IDLE && gnt_any) begin
      ptr_q     <= gnt_idx;
      ar_idx_q  <= gnt_idx;
      ar_addr_q <= sel_addr;
      ar_len_q  <= sel_len;
    end
  end

  assign m_arid   = {{(AXI_ID_W-IDX_W){1'b0}}, ar_idx_q};
  assign m_araddr = ar_addr_q;
  assign m_arlen  = ar_len_q;

  // A beat is only steered when its id maps to a requester with a burst in flight;
  // anything else is drained so a stray id can never wedge the R channel.
  assign r_idx = m_rid[IDX_W-1:0];

  always_comb begin
    beat_ok    = 1'b0;
    sel_rready = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if ((m_rid[AXI_ID_W-1:IDX_W] == '0) && (r_idx == IDX_W'(i)) && (cnt_q[i] != '0)) begin
        beat_ok    = 1'b1;
        sel_rready = req_r_ready[i];
      end
    end
    m_rready = beat_ok ? sel_rready : 1'b1;
    for (int unsigned i = 0; i < NREQ; i++) begin
      req_r_valid[i] = beat_ok && m_rvalid && (r_idx == IDX_W'(i));
    end
  end

  assign req_r_data = m_rdata;
  assign req_r_resp = m_rresp;
  assign req_r_last = m_rlast;

  assign ar_fire = (state_q == ISSUE) && m_arready;
  assign r_fire  = m_rvalid && m_rready;
  assign err_d   = err_q || (r_fire && !beat_ok);

  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      cnt_d[i] = cnt_q[i];
      if (ar_fire && (ar_idx_q == IDX_W'(i)) && !(r_fire && beat_ok && m_rlast && (r_idx == IDX_W'(i))))
        cnt_d[i] = cnt_q[i] + 1'b1;
      else if (!(ar_fire && (ar_idx_q == IDX_W'(i))) && r_fire && beat_ok && m_rlast && (r_idx == IDX_W'(i)))
        cnt_d[i] = cnt_q[i] - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
      for (int unsigned i = 0; i < NREQ; i++) cnt_q[i] <= '0;
    end else begin
      err_q <= err_d;
      for (int unsigned i = 0; i < NREQ; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign err = err_q;

`ifdef HU_SYSARRAY_ARB_PERF_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                            stall_q <= '0;
    else if (m_arvalid && !m_arready && stall_q != '1)  stall_q <= stall_q + 32'd1;
  end

  assign perf_ar_stall_cnt = stall_q;
`else
  assign perf_ar_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_hu_sysarray_rd_arb.sv
// Scoreboard bench for hu_sysarray_rd_arb: a negedge monitor runs a transaction-level
// model (outstanding counts, RR pointer, pending-AR queue) and checks every cycle.
module tb_hu_sysarray_rd_arb;
  localparam int NREQ = 3;
  localparam int MAXO = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      arv;
  logic [NREQ-1:0]      req_ar_valid, req_ar_ready;
  logic [NREQ*32-1:0]   req_ar_addr;
  logic [NREQ*8-1:0]    req_ar_len;
  logic [NREQ-1:0]      req_r_valid, req_r_ready;
  logic [63:0]          req_r_data;
  logic [1:0]           req_r_resp;
  logic                 req_r_last;
  logic                 m_arvalid, m_arready;
  logic [9:0]           m_arid;
  logic [31:0]          m_araddr;
  logic [7:0]           m_arlen;
  logic                 m_rvalid, m_rready;
  logic [9:0]           m_rid;
  logic [63:0]          m_rdata;
  logic [1:0]           m_rresp;
  logic                 m_rlast;
  logic                 err;
  logic [31:0]          perf_ar_stall_cnt;

  assign req_ar_valid = arv;

  always #5 clk = ~clk;

  hu_sysarray_rd_arb #(.NREQ(NREQ), .MAX_OUTST(MAXO)) dut (
    .clk(clk), .rst(rst),
    .req_ar_valid(req_ar_valid), .req_ar_ready(req_ar_ready),
    .req_ar_addr(req_ar_addr), .req_ar_len(req_ar_len),
    .req_r_valid(req_r_valid), .req_r_ready(req_r_ready),
    .req_r_data(req_r_data), .req_r_resp(req_r_resp), .req_r_last(req_r_last),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_arid(m_arid),
    .m_araddr(m_araddr), .m_arlen(m_arlen),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rid(m_rid),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
    .err(err), .perf_ar_stall_cnt(perf_ar_stall_cnt)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model state
  typedef struct { int id; logic [31:0] addr; logic [7:0] len; } ar_t;
  ar_t     arq[$];
  int      mcnt[NREQ];
  int      mptr;
  bit      missue, merr;
  longint  mperf;
  bit      acc[NREQ];

  // Monitor temporaries
  int              c, inc_id, dec_id;
  bit              found, ok, rr_exp, issue_nx, err_nx;
  logic [NREQ-1:0] exp_rdy, exp_rv;
  longint          perf_exp;

  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREQ; i++) begin mcnt[i] = 0; acc[i] = 0; end
      mptr = 0; missue = 0; merr = 0; mperf = 0;
      arq.delete();
      chk("rst_arvalid", m_arvalid, 0);
      chk("rst_arid", m_arid, 0);
      chk("rst_araddr", m_araddr, 0);
      chk("rst_arlen", m_arlen, 0);
      chk("rst_err", err, 0);
      chk("rst_perf", perf_ar_stall_cnt, 0);
      chk("rst_r_valid", req_r_valid, 0);
    end else begin
      inc_id = -1; dec_id = -1; issue_nx = missue; err_nx = merr;
`ifdef HU_SYSARRAY_ARB_PERF_EN
      perf_exp = mperf;
`else
      perf_exp = 0;
`endif
      chk("perf_stall", perf_ar_stall_cnt, perf_exp);
      chk("err", err, merr);

      // R steering: a beat belongs to requester rid only if that requester has bursts in flight
      ok     = (m_rid < NREQ) ? (mcnt[m_rid] != 0) : 1'b0;
      rr_exp = ok ? (((req_r_ready >> m_rid) & 1) != 0) : 1'b1;
      exp_rv = (ok && m_rvalid) ? (NREQ'(1) << m_rid) : '0;
      chk("r_valid", req_r_valid, exp_rv);
      chk("m_rready", m_rready, rr_exp);
      if (m_rvalid && ok) begin
        chk("r_data", req_r_data, m_rdata);
        chk("r_last", req_r_last, m_rlast);
      end
      if (m_rvalid && rr_exp) begin
        if (!ok) err_nx = 1;
        else if (m_rlast) dec_id = int'(m_rid);
      end

      // AR side
      exp_rdy = '0;
      chk("ar_valid", m_arvalid, missue);
      if (missue) begin
        chk("arq_depth", arq.size(), 1);
        if (arq.size() > 0) begin
          chk("ar_id", m_arid, arq[0].id);
          chk("ar_addr", m_araddr, arq[0].addr);
          chk("ar_len", m_arlen, arq[0].len);
          if (m_arready) begin
            inc_id = arq[0].id;
            void'(arq.pop_front());
            issue_nx = 0;
          end else begin
            mperf++;
          end
        end
      end else begin
        found = 0;
        for (int k = 1; k <= NREQ; k++) begin
          c = (mptr + k) % NREQ;
          if (!found && req_ar_valid[c] && mcnt[c] < MAXO) begin
            found = 1;
            exp_rdy[c] = 1'b1;
            arq.push_back('{c, req_ar_addr[32*c +: 32], req_ar_len[8*c +: 8]});
            mptr = c;
            acc[c] = 1;
            issue_nx = 1;
          end
        end
      end
      chk("ar_ready", req_ar_ready, exp_rdy);

      if (inc_id >= 0) mcnt[inc_id]++;
      if (dec_id >= 0) mcnt[dec_id]--;
      missue = issue_nx;
      merr   = err_nx;
    end
  end

  // Driver controls
  int              ar_prob = 0;
  logic [NREQ-1:0] ar_mask = '0;
  bit              rand_ar = 0;
  bit              r_rand  = 0;

  task automatic step();
    int ids[$];
    @(posedge clk); #1;
    for (int i = 0; i < NREQ; i++) begin
      if (acc[i]) begin arv[i] = 1'b0; acc[i] = 0; end
      if (!arv[i] && ar_mask[i] && $urandom_range(99) < ar_prob) begin
        arv[i] = 1'b1;
        req_ar_addr[32*i +: 32] = $urandom;
        req_ar_len[8*i +: 8]    = 8'($urandom);
      end
    end
    if (rand_ar) m_arready = 1'($urandom_range(1));
    if (r_rand) begin
      for (int i = 0; i < NREQ; i++) if (mcnt[i] > 0) ids.push_back(i);
      req_r_ready = NREQ'($urandom_range(7));
      if (ids.size() > 0 && $urandom_range(3) != 0) begin
        m_rvalid = 1'b1;
        m_rid    = 10'(ids[$urandom_range(ids.size() - 1)]);
        m_rlast  = ($urandom_range(2) == 0);
        m_rdata  = {$urandom, $urandom};
        m_rresp  = 2'($urandom);
      end else begin
        m_rvalid = 1'b0;
      end
    end
  endtask

  initial begin
    rst = 1'b1; arv = '0; req_ar_addr = '0; req_ar_len = '0;
    req_r_ready = '1; m_arready = 1'b0; m_rvalid = 1'b0; m_rid = '0;
    m_rdata = '0; m_rresp = '0; m_rlast = 1'b0;
    repeat (3) step();
    rst = 1'b0;

    // Single requester 1, AR held off for 5 cycles
    arv[1] = 1'b1; req_ar_addr[63:32] = 32'h1000; req_ar_len[15:8] = 8'd7;
    repeat (6) step();
    m_arready = 1'b1;
    repeat (2) step();
`ifdef HU_SYSARRAY_ARB_PERF_EN
    chk("perf_after_hold", perf_ar_stall_cnt, 5);
`endif

    // All requesters continuously valid, then saturate outstanding limits
    ar_mask = '1; ar_prob = 100;
    repeat (40) step();
    // One burst completes for requester 0, which must be granted again
    m_rvalid = 1'b1; m_rid = 10'd0; m_rlast = 1'b1; m_rdata = 64'hABCD_0000_1234_5678;
    step();
    m_rvalid = 1'b0; m_rlast = 1'b0;
    repeat (6) step();
    ar_mask = '0;

    // Interleaved beats for ids 2 and 1, requester 2 back-pressuring at first
    for (int j = 0; j < 8; j++) begin
      m_rvalid = 1'b1; m_rid = (j % 2) ? 10'd1 : 10'd2; m_rlast = 1'b0;
      m_rdata = {32'(j), $urandom};
      req_r_ready = (j < 4) ? 3'b011 : 3'b111;
      step();
    end
    m_rvalid = 1'b0;

    // Randomised legal traffic
    ar_mask = '1; ar_prob = 40; rand_ar = 1; r_rand = 1;
    repeat (600) step();
    r_rand = 0; rand_ar = 0; ar_prob = 0; m_rvalid = 1'b0; m_arready = 1'b1;
    repeat (6) step();
    chk("err_clean", err, 0);

    // Unsolicited beats
    req_r_ready = '0; m_rvalid = 1'b1; m_rlast = 1'b1; m_rid = 10'd3;
    step();
    m_rid = 10'h041;
    step();
    m_rvalid = 1'b0; m_rlast = 1'b0; req_r_ready = '1;
    repeat (3) step();
    chk("err_sticky", err, 1);

    // Reset during an outstanding len-15 burst
    if (!arv[2]) begin
      arv[2] = 1'b1; req_ar_addr[95:64] = 32'h2000_0000; req_ar_len[23:16] = 8'd15;
    end
    repeat (4) step();
    m_rvalid = 1'b1; m_rid = 10'd2; m_rlast = 1'b0;
    repeat (3) step();
    rst = 1'b1; arv = '0; m_rvalid = 1'b0;
    repeat (2) step();
    rst = 1'b0;
    step();
    chk("err_cleared_by_rst", err, 0);
    m_rvalid = 1'b1; m_rid = 10'd2; m_rlast = 1'b0; req_r_ready = '0;
    step();
    m_rvalid = 1'b0;
    repeat (2) step();
    chk("err_after_rst_drain", err, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
